// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 memory arbiter slice.
package mips32_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    REQ_IF   = 2'd0,
    REQ_DATA = 2'd1,
    REQ_DBG  = 2'd2,
    REQ_NONE = 2'd3
  } req_id_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mips32_arb_prio.sv
// Three-way fixed-priority pick (DBG > DATA > IF) with an IF boost that lets a
// starved fetch beat DATA once, and a debug lock that masks IF and DATA.
module mips32_arb_prio
  import mips32_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic dbg_req,
  input  logic dbg_lock,
  input  logic if_boost,
  output logic if_win,
  output logic d_win,
  output logic dbg_win
);

  logic pipe_ok;

  // DBG always wins; IF and DATA compete only when DBG is quiet and not locking.
  always_comb begin
    pipe_ok = !dbg_req && !dbg_lock;
    dbg_win = dbg_req;
    d_win   = pipe_ok && d_req && !(if_boost && if_req);
    if_win  = pipe_ok && if_req && (!d_req || if_boost);
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Shares one fixed-latency memory between IF, DATA and DBG requesters with a
// single access in flight; a new grant may overlap the completing cycle.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  arb_state_t        state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
  req_id_t           owner, owner_nxt;
  logic              owner_we, owner_we_nxt;
  logic [STV_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic [DATA_W-1:0] rdata_q;
  logic              last_cycle, grant_ok, if_boost;
  logic              if_win, d_win, dbg_win;

  assign last_cycle = (state == BUSY) && (lat_cnt == LAT_W'(1));
  assign grant_ok   = (state == IDLE) || last_cycle;
  assign if_boost   = (starve_cnt == STV_W'(STARVE_MAX));

  mips32_arb_prio u_prio (
    .if_req   (if_req),
    .d_req    (d_req),
    .dbg_req  (dbg_req),
    .dbg_lock (dbg_lock),
    .if_boost (if_boost),
    .if_win   (if_win),
    .d_win    (d_win),
    .dbg_win  (dbg_win)
  );

  // Registers the access in flight, the starvation count and the last read word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      owner      <= REQ_NONE;
      owner_we   <= 1'b0;
      starve_cnt <= '0;
      rdata_q    <= '0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      owner      <= owner_nxt;
      owner_we   <= owner_we_nxt;
      starve_cnt <= starve_cnt_nxt;
      if (last_cycle && !owner_we) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Completion strobes, grant/memory mux from the winner, and next-state logic.
  always_comb begin
    state_nxt      = state;
    lat_cnt_nxt    = lat_cnt;
    owner_nxt      = owner;
    owner_we_nxt   = owner_we;
    starve_cnt_nxt = starve_cnt;
    if_gnt         = 1'b0;
    d_gnt          = 1'b0;
    dbg_gnt        = 1'b0;
    if_rvalid      = 1'b0;
    d_rvalid       = 1'b0;
    dbg_rvalid     = 1'b0;
    rdata          = rdata_q;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;

    if (state == BUSY) begin
      if (last_cycle) begin
        case (owner)
          REQ_IF:   if_rvalid  = 1'b1;
          REQ_DATA: d_rvalid   = 1'b1;
          REQ_DBG:  dbg_rvalid = 1'b1;
          default:  ;
        endcase
        if (!owner_we) begin
          rdata = mem_rdata;
        end
        state_nxt    = IDLE;
        lat_cnt_nxt  = '0;
        owner_nxt    = REQ_NONE;
        owner_we_nxt = 1'b0;
      end else begin
        lat_cnt_nxt = lat_cnt - LAT_W'(1);
      end
    end

    if (grant_ok) begin
      if (dbg_win) begin
        dbg_gnt      = 1'b1;
        mem_we       = dbg_we;
        mem_addr     = dbg_addr;
        mem_wdata    = dbg_wdata;
        owner_nxt    = REQ_DBG;
        owner_we_nxt = dbg_we;
      end else if (d_win) begin
        d_gnt        = 1'b1;
        mem_we       = d_we;
        mem_addr     = d_addr;
        mem_wdata    = d_wdata;
        owner_nxt    = REQ_DATA;
        owner_we_nxt = d_we;
      end else if (if_win) begin
        if_gnt       = 1'b1;
        mem_addr     = if_addr;
        owner_nxt    = REQ_IF;
        owner_we_nxt = 1'b0;
      end
      if (dbg_win || d_win || if_win) begin
        mem_en      = 1'b1;
        state_nxt   = BUSY;
        lat_cnt_nxt = LAT_W'(MEM_LAT);
      end
    end

    if (!dbg_lock) begin
      if (!if_req || if_gnt) begin
        starve_cnt_nxt = '0;
      end else if ((d_gnt || dbg_gnt) && (starve_cnt != STV_W'(STARVE_MAX))) begin
        starve_cnt_nxt = starve_cnt + STV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench: one arbiter with MEM_LAT=1 and one with MEM_LAT=3 share the
// requester inputs; each has its own memory model behind it.
module tb_mips32_mem_arbiter;

  typedef struct {
    logic        if_req;
    logic [9:0]  if_addr;
    logic        d_req;
    logic        d_we;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        dbg_req;
    logic        dbg_we;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_lock;
    logic [7:0]  exp_flags;
    logic [31:0] exp_rdata;
    logic [9:0]  exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  logic clk, rst;
  logic if_req, d_req, d_we, dbg_req, dbg_we, dbg_lock;
  logic [9:0] if_addr, d_addr, dbg_addr;
  logic [31:0] d_wdata, dbg_wdata;

  logic if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, dbg_gnt1, dbg_rvalid1, mem_en1, mem_we1;
  logic [31:0] rdata1, mem_wdata1, mem_rdata1;
  logic [9:0] mem_addr1;
  logic if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, dbg_gnt3, dbg_rvalid3, mem_en3, mem_we3;
  logic [31:0] rdata3, mem_wdata3, mem_rdata3;
  logic [9:0] mem_addr3;

  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] rd1, p0, p1, p2;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs [15];

  mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt1), .dbg_rvalid(dbg_rvalid1),
    .rdata(rdata1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt3), .dbg_rvalid(dbg_rvalid3),
    .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = (i == 5) ? 32'h0000_1234 : (32'hA000_0000 | 32'(i));
    return w;
  endfunction

  // Single-cycle synchronous memory behind the MEM_LAT=1 arbiter.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem1[i] <= init_word(i);
      rd1 <= '0;
    end else if (mem_en1) begin
      if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
      else rd1 <= mem1[mem_addr1];
    end
  end
  assign mem_rdata1 = rd1;

  // Three-stage read pipeline behind the MEM_LAT=3 arbiter.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem3[i] <= init_word(i);
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
    end else begin
      if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
      if (mem_en3 && !mem_we3) p0 <= mem3[mem_addr3];
      p1 <= p0;
      p2 <= p1;
    end
  end
  assign mem_rdata3 = p2;

  function automatic vec_t mk(
    input logic ifr, input logic [9:0] ifa,
    input logic dr, input logic dwe, input logic [9:0] da, input logic [31:0] dwd,
    input logic gr, input logic gwe, input logic [9:0] ga, input logic [31:0] gwd,
    input logic lk, input logic [7:0] ef, input logic [31:0] erd,
    input logic [9:0] ea, input logic [31:0] ewd);
    vec_t v;
    v.if_req = ifr;  v.if_addr = ifa;
    v.d_req = dr;    v.d_we = dwe;   v.d_addr = da;   v.d_wdata = dwd;
    v.dbg_req = gr;  v.dbg_we = gwe; v.dbg_addr = ga; v.dbg_wdata = gwd;
    v.dbg_lock = lk; v.exp_flags = ef; v.exp_rdata = erd;
    v.exp_addr = ea; v.exp_wdata = ewd;
    return v;
  endfunction

  function automatic vec_t mk_idle(input logic [7:0] ef, input logic [31:0] erd);
    return mk(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0,
              1'b0, ef, erd, 10'd0, 32'h0);
  endfunction

  function automatic logic [7:0] flags1();
    return {if_gnt1, d_gnt1, dbg_gnt1, if_rvalid1, d_rvalid1, dbg_rvalid1, mem_en1, mem_we1};
  endfunction

  function automatic logic [7:0] flags3();
    return {if_gnt3, d_gnt3, dbg_gnt3, if_rvalid3, d_rvalid3, dbg_rvalid3, mem_en3, mem_we3};
  endfunction

  task automatic set_idle();
    if_req = 1'b0;  if_addr = '0;
    d_req = 1'b0;   d_we = 1'b0;   d_addr = '0;   d_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    dbg_lock = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    if_req = v.if_req;   if_addr = v.if_addr;
    d_req = v.d_req;     d_we = v.d_we;     d_addr = v.d_addr;     d_wdata = v.d_wdata;
    dbg_req = v.dbg_req; dbg_we = v.dbg_we; dbg_addr = v.dbg_addr; dbg_wdata = v.dbg_wdata;
    dbg_lock = v.dbg_lock;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();

    // flags = {if_gnt,d_gnt,dbg_gnt,if_rvalid,d_rvalid,dbg_rvalid,mem_en,mem_we}
    vecs[0]  = mk(1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0,
                  1'b0, 8'b100_000_10, 32'h0, 10'd5, 32'h0);
    vecs[1]  = mk_idle(8'b000_100_00, 32'h0000_1234);
    vecs[2]  = mk_idle(8'b000_000_00, 32'h0000_1234);
    vecs[3]  = mk(1'b1, 10'd2, 1'b1, 1'b0, 10'd1, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0,
                  1'b0, 8'b010_000_10, 32'h0000_1234, 10'd1, 32'h0);
    vecs[4]  = mk(1'b1, 10'd2, 1'b1, 1'b0, 10'd1, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0,
                  1'b0, 8'b010_010_10, 32'hA000_0001, 10'd1, 32'h0);
    vecs[5]  = vecs[4];
    vecs[6]  = vecs[4];
    vecs[7]  = mk(1'b1, 10'd2, 1'b1, 1'b0, 10'd1, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0,
                  1'b0, 8'b100_010_10, 32'hA000_0001, 10'd2, 32'h0);
    vecs[8]  = mk(1'b1, 10'd2, 1'b1, 1'b0, 10'd1, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0,
                  1'b0, 8'b010_100_10, 32'hA000_0002, 10'd1, 32'h0);
    vecs[9]  = mk_idle(8'b000_010_00, 32'hA000_0001);
    vecs[10] = mk(1'b1, 10'd3, 1'b1, 1'b0, 10'd4, 32'h0, 1'b1, 1'b1, 10'd10, 32'h0000_DEAD,
                  1'b1, 8'b001_000_11, 32'hA000_0001, 10'd10, 32'h0000_DEAD);
    vecs[11] = mk(1'b1, 10'd3, 1'b1, 1'b0, 10'd4, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0,
                  1'b1, 8'b000_001_00, 32'hA000_0001, 10'd0, 32'h0);
    vecs[12] = mk(1'b0, 10'd0, 1'b1, 1'b0, 10'd10, 32'h0, 1'b0, 1'b0, 10'd0, 32'h0,
                  1'b0, 8'b010_000_10, 32'hA000_0001, 10'd10, 32'h0);
    vecs[13] = mk_idle(8'b000_010_00, 32'h0000_DEAD);
    vecs[14] = mk_idle(8'b000_000_00, 32'h0000_DEAD);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset flags", 32'(flags1()), 32'h0);
    checkOutput("reset rdata", rdata1, 32'h0);
    checkOutput("reset mem_addr", 32'(mem_addr1), 32'h0);
    checkOutput("reset mem_wdata", mem_wdata1, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Solo IF read, DATA/IF starvation run and locked DBG write, MEM_LAT=1.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d flags", i), 32'(flags1()), 32'(vecs[i].exp_flags));
      checkOutput($sformatf("vec%0d rdata", i), rdata1, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d mem_addr", i), 32'(mem_addr1), 32'(vecs[i].exp_addr));
      checkOutput($sformatf("vec%0d mem_wdata", i), mem_wdata1, vecs[i].exp_wdata);
    end

    // MEM_LAT=3 back-to-back DATA reads of addr 1 then addr 2.
    @(posedge clk);
    #1 rst = 1'b1;
    set_idle();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      d_req  = (k <= 3);
      d_addr = (k == 0) ? 10'd1 : 10'd2;
      @(negedge clk);
      checkOutput($sformatf("lat3 d_gnt c%0d", k), 32'(d_gnt3), 32'((k == 0) || (k == 3)));
      checkOutput($sformatf("lat3 d_rvalid c%0d", k), 32'(d_rvalid3), 32'((k == 3) || (k == 6)));
      if (k == 3) checkOutput("lat3 rdata first", rdata3, 32'hA000_0001);
      if (k == 6) checkOutput("lat3 rdata second", rdata3, 32'hA000_0002);
    end

    // IF asks while DATA is busy, then withdraws before it could be granted.
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      d_req   = (k == 0);
      d_addr  = 10'd1;
      if_req  = (k <= 1);
      if_addr = 10'd6;
      @(negedge clk);
      checkOutput($sformatf("wd if_gnt c%0d", k), 32'(if_gnt3), 32'h0);
      checkOutput($sformatf("wd if_rvalid c%0d", k), 32'(if_rvalid3), 32'h0);
      checkOutput($sformatf("wd mem_en c%0d", k), 32'(mem_en3), 32'(k == 0));
      checkOutput($sformatf("wd d_rvalid c%0d", k), 32'(d_rvalid3), 32'(k == 3));
    end

    // Reset in the middle of a MEM_LAT=3 read drops the access entirely.
    @(posedge clk);
    #1;
    d_req  = 1'b1;
    d_addr = 10'd4;
    @(negedge clk);
    checkOutput("rstmid d_gnt", 32'(d_gnt3), 32'h1);
    @(posedge clk);
    #1;
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid flags", 32'(flags3()), 32'h0);
    checkOutput("rstmid rdata", rdata3, 32'h0);
    checkOutput("rstmid mem_addr", 32'(mem_addr3), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rstmid quiet c%0d", k), 32'(flags3()), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
